udp_tx_pkt_gen: RTL and testbench

Parametrised multi-packet payload source that drives the existing UDP/IP transmit block (my_ip_send). It sequences N packets (or runs continuously), with configurable payload length, inter-packet gap and payload mode (incrementing, PRBS, constant). It serves the sender's read_data_req with registered payload words. A send_end watchdog and sticky error flags make it usable as an on-board loopback/BIST traffic generator.

---
 rtl/udp_tx_pkt_gen.sv | 209 ++++++++++++++++++++
 tb/tb_udp_tx_pkt_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_pkt_gen.sv
// Multi-packet UDP payload source for my_ip_send: sequences packets, gaps and payload words.
// send_en rises one cycle after start; each word is registered on the request edge; pacing is set by the sender's requests.
module udp_tx_pkt_gen #(
  parameter int          DATA_W    = 32,
  parameter int          LEN_W     = 16,
  parameter int          CNT_W     = 16,
  parameter int          GAP_W     = 16,
  parameter int          TIMEOUT   = 65535,
  parameter logic [31:0] PRBS_SEED = 32'h0000_0001
) (
  input  logic              eth_tx_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        cfg_mode,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  cfg_pkt_num,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [DATA_W-1:0] cfg_pattern,
  output logic              send_en,
  output logic [LEN_W-1:0]  send_data_num,
  output logic [DATA_W-1:0] send_data,
  input  logic              read_data_req,
  input  logic              send_end,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              overrun_err,
  output logic              timeout_err
);

  localparam int BPW_LG = (DATA_W == 8) ? 0 : (DATA_W == 16) ? 1 : 2;
  localparam int BPW    = DATA_W / 8;
  localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_END,
    S_GAP,
    S_FINISH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [1:0]         r_mode;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_pkt_num;
  logic [GAP_W-1:0]   r_gap;
  logic [DATA_W-1:0]  r_pattern;
  logic [LEN_W:0]     r_exp_words;
  logic [LEN_W:0]     r_word_idx;
  logic [DATA_W-1:0]  r_inc;
  logic [31:0]        r_lfsr;
  logic [DATA_W-1:0]  r_send_data;
  logic [CNT_W-1:0]   r_pkt_cnt;
  logic               r_overrun_err;
  logic               r_timeout_err;
  logic               r_stop_pending;
  logic [WD_W-1:0]    r_wd;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic               w_start;
  logic               w_serve;
  logic               w_overrun;
  logic               w_complete;
  logic               w_timeout;
  logic               w_last;
  logic [CNT_W-1:0]   w_pkt_cnt_inc;
  logic [LEN_W:0]     w_exp_calc;
  logic               w_lfsr_fb;

  // Word count rounds the byte length up to whole DATA_W words.
  assign w_exp_calc = ({1'b0, cfg_len} + (LEN_W+1)'(BPW - 1)) >> BPW_LG;
  assign w_lfsr_fb  = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];

  always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    send_en       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    w_start       = 1'b0;
    w_serve       = 1'b0;
    w_overrun     = 1'b0;
    w_complete    = 1'b0;
    w_timeout     = 1'b0;
    w_pkt_cnt_inc = r_pkt_cnt + CNT_W'(1);
    w_last        = stop || r_stop_pending ||
                    ((r_pkt_num != '0) && (w_pkt_cnt_inc == r_pkt_num));
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_start     = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        send_en     = 1'b1;
        w_state_nxt = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (read_data_req) begin
          if (r_word_idx < r_exp_words) w_serve   = 1'b1;
          else                          w_overrun = 1'b1;
        end
        if (send_end) begin
          w_complete = 1'b1;
          if (w_last)              w_state_nxt = S_FINISH;
          else if (r_gap != '0)    w_state_nxt = S_GAP;
          else                     w_state_nxt = S_LAUNCH;
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_FINISH;
        end
      end
      S_GAP: begin
        if (stop || r_stop_pending)              w_state_nxt = S_FINISH;
        else if (r_gap_cnt == r_gap - GAP_W'(1)) w_state_nxt = S_LAUNCH;
      end
      S_FINISH: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode         <= '0;
      r_len          <= '0;
      r_pkt_num      <= '0;
      r_gap          <= '0;
      r_pattern      <= '0;
      r_exp_words    <= '0;
      r_word_idx     <= '0;
      r_inc          <= '0;
      r_lfsr         <= PRBS_SEED;
      r_send_data    <= '0;
      r_pkt_cnt      <= '0;
      r_overrun_err  <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_stop_pending <= 1'b0;
      r_wd           <= '0;
      r_gap_cnt      <= '0;
    end else begin
      if (stop && (r_state != S_IDLE)) r_stop_pending <= 1'b1;

      if (w_start) begin
        r_mode         <= cfg_mode;
        r_len          <= cfg_len;
        r_pkt_num      <= cfg_pkt_num;
        r_gap          <= cfg_gap;
        r_pattern      <= cfg_pattern;
        r_exp_words    <= w_exp_calc;
        r_pkt_cnt      <= '0;
        r_overrun_err  <= 1'b0;
        r_timeout_err  <= 1'b0;
        r_inc          <= '0;
        r_lfsr         <= PRBS_SEED;
        r_stop_pending <= 1'b0;
      end

      if (r_state == S_LAUNCH) begin
        r_word_idx <= '0;
        r_wd       <= '0;
      end else if (r_state == S_WAIT_END) begin
        r_wd <= r_wd + WD_W'(1);
      end

      // Sequence generators advance only on served words, so they run on across packets.
      if (w_serve) begin
        r_word_idx <= r_word_idx + (LEN_W+1)'(1);
        case (r_mode)
          2'd1: begin
            r_send_data <= r_lfsr[31 -: DATA_W];
            r_lfsr      <= {r_lfsr[30:0], w_lfsr_fb};
          end
          2'd2: r_send_data <= r_pattern;
          default: begin
            r_send_data <= r_inc;
            r_inc       <= r_inc + DATA_W'(1);
          end
        endcase
      end

      if (w_overrun)  r_overrun_err <= 1'b1;
      if (w_timeout)  r_timeout_err <= 1'b1;
      if (w_complete) r_pkt_cnt     <= w_pkt_cnt_inc;

      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      else                  r_gap_cnt <= '0;
    end
  end

  assign send_data_num = r_len;
  assign send_data     = r_send_data;
  assign pkt_cnt       = r_pkt_cnt;
  assign overrun_err   = r_overrun_err;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_udp_tx_pkt_gen.sv
// Directed bench for udp_tx_pkt_gen: single-packet vector table plus gap, PRBS continuation,
// stop, watchdog and async-reset sequences.
module tb_udp_tx_pkt_gen;

  logic        eth_tx_clk = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        start      = 1'b0;
  logic        stop       = 1'b0;
  logic [1:0]  cfg_mode   = '0;
  logic [15:0] cfg_len    = '0;
  logic [15:0] cfg_pkt_num = '0;
  logic [15:0] cfg_gap    = '0;
  logic [31:0] cfg_pattern = '0;
  logic        read_data_req = 1'b0;
  logic        send_end   = 1'b0;
  logic        send_en;
  logic [15:0] send_data_num;
  logic [31:0] send_data;
  logic        busy;
  logic        done;
  logic [15:0] pkt_cnt;
  logic        overrun_err;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  udp_tx_pkt_gen #(
    .DATA_W(32), .LEN_W(16), .CNT_W(16), .GAP_W(16),
    .TIMEOUT(100), .PRBS_SEED(32'h0000_0001)
  ) dut (
    .eth_tx_clk(eth_tx_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_pkt_num(cfg_pkt_num),
    .cfg_gap(cfg_gap), .cfg_pattern(cfg_pattern), .send_en(send_en),
    .send_data_num(send_data_num), .send_data(send_data),
    .read_data_req(read_data_req), .send_end(send_end), .busy(busy), .done(done),
    .pkt_cnt(pkt_cnt), .overrun_err(overrun_err), .timeout_err(timeout_err)
  );

  always #5 eth_tx_clk = ~eth_tx_clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] len;
    logic [31:0] pattern;
    int          nreq;
    logic [31:0] words [4];
    logic        ovr;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge eth_tx_clk);
    #1;
  endtask

  // Leaves the bench in the LAUNCH cycle; cfg is scrambled afterwards to prove it was latched.
  task automatic run_start(input logic [1:0] mode, input logic [15:0] len,
                           input logic [15:0] num, input logic [15:0] gap,
                           input logic [31:0] pat);
    cfg_mode = mode; cfg_len = len; cfg_pkt_num = num; cfg_gap = gap; cfg_pattern = pat;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_mode = 2'd2; cfg_len = 16'h0BAD; cfg_pkt_num = 16'd7; cfg_gap = 16'd5;
    cfg_pattern = 32'h1234_5678;
  endtask

  task automatic wait_send_en(input int limit, output int n);
    n = 0;
    while (send_en !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_end();
    send_end = 1'b1;
    tick();
    send_end = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;

    vecs[0] = '{2'd0, 16'd8,  32'h0,         2, '{32'h0, 32'h1, 32'h0, 32'h0}, 1'b0};
    vecs[1] = '{2'd2, 16'd4,  32'hA5A5_5A5A, 1, '{32'hA5A5_5A5A, 32'h0, 32'h0, 32'h0}, 1'b0};
    vecs[2] = '{2'd1, 16'd12, 32'h0,         3, '{32'h1, 32'h3, 32'h6, 32'h0}, 1'b0};
    vecs[3] = '{2'd0, 16'd5,  32'h0,         3, '{32'h0, 32'h1, 32'h1, 32'h0}, 1'b1};
    vecs[4] = '{2'd3, 16'd16, 32'h0,         4, '{32'h0, 32'h1, 32'h2, 32'h3}, 1'b0};
    vecs[5] = '{2'd0, 16'd0,  32'h0,         1, '{32'h3, 32'h0, 32'h0, 32'h0}, 1'b1};
    vecs[6] = '{2'd0, 16'd7,  32'h0,         2, '{32'h0, 32'h1, 32'h0, 32'h0}, 1'b0};

    #2;
    chk("rst_send_en", {31'd0, send_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_send_data", send_data, 32'd0);
    chk("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
    @(negedge eth_tx_clk);
    @(negedge eth_tx_clk);
    sys_rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_start(vecs[i].mode, vecs[i].len, 16'd1, 16'd0, vecs[i].pattern);
      chk($sformatf("v%0d_send_en", i), {31'd0, send_en}, 32'd1);
      chk($sformatf("v%0d_num", i), {16'd0, send_data_num}, {16'd0, vecs[i].len});
      tick();
      chk($sformatf("v%0d_send_en_low", i), {31'd0, send_en}, 32'd0);
      for (int r = 0; r < vecs[i].nreq; r++) begin
        read_data_req = 1'b1;
        tick();
        chk($sformatf("v%0d_word%0d", i, r), send_data, vecs[i].words[r]);
      end
      read_data_req = 1'b0;
      chk($sformatf("v%0d_overrun", i), {31'd0, overrun_err}, {31'd0, vecs[i].ovr});
      pulse_end();
      chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      chk($sformatf("v%0d_pkt_cnt", i), {16'd0, pkt_cnt}, 32'd1);
      tick();
      chk($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_idle_done", i), {31'd0, done}, 32'd0);
    end

    // Three packets with a 10-cycle gap; a start while busy must be ignored.
    run_start(2'd0, 16'd4, 16'd3, 16'd10, 32'h0);
    chk("gap_send_en0", {31'd0, send_en}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      if (p > 0) begin
        wait_send_en(50, n);
        chk($sformatf("gap_delay%0d", p), n, 32'd10);
      end
      if (p == 1) start = 1'b1;
      tick();
      start = 1'b0;
      pulse_end();
      if (p < 2) begin
        chk($sformatf("gap_busy%0d", p), {31'd0, busy}, 32'd1);
        chk($sformatf("gap_pkt_cnt%0d", p), {16'd0, pkt_cnt}, p + 1);
      end
    end
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
    tick();
    chk("gap_busy_end", {31'd0, busy}, 32'd0);

    // PRBS sequence continues into the second packet.
    run_start(2'd1, 16'd12, 16'd2, 16'd0, 32'h0);
    tick();
    for (int r = 0; r < 3; r++) begin
      read_data_req = 1'b1;
      tick();
    end
    read_data_req = 1'b0;
    chk("prbs_word2", send_data, 32'h6);
    pulse_end();
    chk("prbs_relaunch", {31'd0, send_en}, 32'd1);
    tick();
    read_data_req = 1'b1;
    tick();
    read_data_req = 1'b0;
    chk("prbs_word3", send_data, 32'hD);
    pulse_end();
    chk("prbs_done", {31'd0, done}, 32'd1);
    chk("prbs_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
    tick();

    // Continuous run stopped during the second packet.
    run_start(2'd0, 16'd4, 16'd0, 16'd2, 32'h0);
    tick();
    pulse_end();
    wait_send_en(20, n);
    chk("stop_gap", n, 32'd2);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    pulse_end();
    chk("stop_done", {31'd0, done}, 32'd1);
    chk("stop_pkt_cnt", {16'd0, pkt_cnt}, 32'd2);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (send_en === 1'b1) seen++;
    end
    chk("stop_no_launch", seen, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);

    // Watchdog: 100 cycles in WAIT_END then FINISH.
    run_start(2'd0, 16'd4, 16'd1, 16'd0, 32'h0);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wd_cycles", n, 32'd101);
    chk("wd_timeout_err", {31'd0, timeout_err}, 32'd1);
    tick();
    run_start(2'd0, 16'd4, 16'd1, 16'd0, 32'h0);
    chk("wd_err_cleared", {31'd0, timeout_err}, 32'd0);
    tick();
    pulse_end();
    chk("wd_clean_done", {31'd0, done}, 32'd1);
    tick();

    // Asynchronous reset in the middle of WAIT_END.
    run_start(2'd2, 16'd4, 16'd1, 16'd0, 32'hDEAD_BEEF);
    tick();
    read_data_req = 1'b1;
    tick();
    chk("arst_pre_data", send_data, 32'hDEAD_BEEF);
    tick();
    read_data_req = 1'b0;
    chk("arst_pre_ovr", {31'd0, overrun_err}, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_send_data", send_data, 32'd0);
    chk("arst_num", {16'd0, send_data_num}, 32'd0);
    chk("arst_ovr", {31'd0, overrun_err}, 32'd0);
    chk("arst_flags", {29'd0, send_en, done, timeout_err}, 32'd0);
    @(negedge eth_tx_clk);
    sys_rst_n = 1'b1;
    tick();
    chk("arst_idle", {30'd0, busy, send_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
